divider_machine: RTL
====================

# divider_machine

Sequential restoring shift-subtract divider with its own control FSM and operand/result registers. It is the inverse counterpart of the shift-add multiplier control machine. It uses the same IDLE/CALC/DONE structure and the same iValid_Data/iAck handshake, so one upstream sequencer can drive either unit. It takes one quotient bit per clock and holds the result until the consumer acknowledges it.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits (≥2)

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- iValid_Data  in  1  operands valid; sampled only in IDLE
- iDividend  in  WIDTH  unsigned dividend
- iDivisor  in  WIDTH  unsigned divisor
- iAck  in  1  consumer has taken the result; sampled only in DONE
- oBusy  out  1  high in CALC
- oDone  out  1  high in DONE; result valid
- oQuotient  out  WIDTH  quotient, registered
- oRemainder  out  WIDTH  remainder, registered
- oDivByZero  out  1  divisor was zero (see Configuration)

## Operation
- State encoding: IDLE=0, CALC=1, DONE=2. Unused codes go to IDLE on the next edge.
- Internal registers:
  - rDivisor: WIDTH bits
  - rQuot: WIDTH bits, shifts in quotient bits
  - rRem: WIDTH+1 bits, partial remainder with borrow bit
  - rCounter: $clog2(WIDTH)+1 bits
- IDLE, iValid_Data=1:
  - Load rDivisor=iDivisor, rQuot=iDividend, rRem=0, rCounter=0.
  - Go to CALC.
- CALC, one iteration per edge:
  - T = {rRem[WIDTH-1:0], rQuot[WIDTH-1]}, WIDTH+1 bits.
  - If T ≥ {0,rDivisor}: rRem=T−rDivisor and shift 1 into rQuot LSB.
  - Otherwise: rRem=T and shift 0 into rQuot LSB.
  - rCounter increments each iteration.
  - When rCounter==WIDTH−1 at the edge: perform the final iteration, go to DONE, and copy rQuot/rRem[WIDTH-1:0] into oQuotient/oRemainder in the same edge.
- DONE:
  - oDone=1; outputs hold.
  - iAck=1 → IDLE on the next edge.
  - iValid_Data is ignored.
- IDLE/CALC: iAck is ignored.
- Division by zero with the restoring algorithm gives oQuotient = all ones and oRemainder = iDividend. This result is architectural.
- Results stay stable from DONE entry until the next accepted operation completes. They are not cleared on return to IDLE.

## Timing
- Reset values:
  - State: IDLE
  - oBusy, oDone, oDivByZero: 0
  - oQuotient, oRemainder: 0
  - Internal registers: 0
- Latency: accept at edge 0. DONE (oDone=1) is visible after edge WIDTH, i.e. WIDTH+1 cycles from acceptance to result (33 for WIDTH=32).
- Throughput: one division per WIDTH+2 cycles minimum, counting the iAck cycle and the return to IDLE.
- Simultaneous iAck and iValid_Data in DONE: go to IDLE only. The new operands are accepted on a later IDLE cycle, so the producer must hold iValid_Data.
- Reset asserted in any state, including mid-CALC: the next edge returns all registers and outputs to reset values. The partial result is discarded.
- Operand inputs are sampled only at the accept edge. Changes during CALC/DONE have no effect.
- All outputs are registered. There are no combinational paths from input to output.

## Configuration
- Macro: DIVIDER_ZERO_SHORTCUT_EN.
- Defined:
  - In IDLE with iValid_Data=1 and iDivisor==0, go directly to DONE on the accept edge.
  - oQuotient = all ones, oRemainder = iDividend, oDivByZero = 1.
  - Latency is 1 cycle.
  - oDivByZero is cleared on the next accept.
- Not defined:
  - A zero divisor runs the full WIDTH iterations and produces the identical quotient/remainder.
  - oDivByZero is tied to 0.
- Nonzero divisors behave identically in both builds.

## Test plan
- Basic division: WIDTH=32, iDividend=100, iDivisor=7, iValid_Data pulse → oDone rises exactly 33 cycles after accept with oQuotient=14, oRemainder=2. iAck → IDLE next edge, outputs unchanged.
- Extremes: 0xFFFFFFFF/1 → Q=0xFFFFFFFF, R=0. Then 5/10 → Q=0, R=5. Then 0x80000000/0xFFFFFFFF → Q=0, R=0x80000000.
- Divide by zero: 1234/0.
  - With DIVIDER_ZERO_SHORTCUT_EN: DONE after 1 cycle, Q=0xFFFFFFFF, R=1234, oDivByZero=1.
  - Without it: same Q/R after 33 cycles, oDivByZero=0.
- Reset mid-operation: start 1000/3, assert Reset at CALC cycle 10 → next edge: IDLE, all outputs 0. Then 9/3 → Q=3, R=0.
- Handshake robustness:
  - Toggle iValid_Data and the operands during CALC → result unaffected.
  - Hold DONE for 5 cycles without iAck → outputs stable.
  - iAck and iValid_Data together in DONE → IDLE, no accept. Accept on the following cycle.
- Random regression: 1000 random nonzero pairs checked against a reference model. Zero divisors are handled by the Configuration checks.

Source files
------------

// File: rtl/divider_machine.sv
// Sequential restoring divider: one quotient bit per clock, result held until acknowledged.
// Optional macro DIVIDER_ZERO_SHORTCUT_EN finishes a zero-divisor request on the accept edge.
module divider_machine #(
   parameter int WIDTH = 32
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             iValid_Data,
   input  logic [WIDTH-1:0] iDividend,
   input  logic [WIDTH-1:0] iDivisor,
   input  logic             iAck,
   output logic             oBusy,
   output logic             oDone,
   output logic [WIDTH-1:0] oQuotient,
   output logic [WIDTH-1:0] oRemainder,
   output logic             oDivByZero
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH-1:0] quot;
   logic [WIDTH:0]   rem;
   logic [CW-1:0]    counter;

   logic [WIDTH:0]   trial;
   logic [WIDTH:0]   diff;
   logic             fits;
   logic [WIDTH:0]   rem_next;
   logic [WIDTH-1:0] quot_next;
   logic             rem_unused;

   // The restored remainder is always below the divisor, so its top bit never carries information.
   assign rem_unused = rem[WIDTH];

   always_comb begin
      trial     = {rem[WIDTH-1:0], quot[WIDTH-1]};
      fits      = (trial >= {1'b0, divisor});
      diff      = trial - {1'b0, divisor};
      rem_next  = fits ? diff : trial;
      quot_next = {quot[WIDTH-2:0], fits};
   end

`ifdef DIVIDER_ZERO_SHORTCUT_EN
   logic div_by_zero;
   assign oDivByZero = div_by_zero;
`else
   assign oDivByZero = 1'b0;
`endif

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state      <= IDLE;
         divisor    <= '0;
         quot       <= '0;
         rem        <= '0;
         counter    <= '0;
         oBusy      <= 1'b0;
         oDone      <= 1'b0;
         oQuotient  <= '0;
         oRemainder <= '0;
`ifdef DIVIDER_ZERO_SHORTCUT_EN
         div_by_zero <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (iValid_Data) begin
                  divisor <= iDivisor;
                  quot    <= iDividend;
                  rem     <= '0;
                  counter <= '0;
                  state   <= CALC;
                  oBusy   <= 1'b1;
`ifdef DIVIDER_ZERO_SHORTCUT_EN
                  div_by_zero <= (iDivisor == '0);
                  if (iDivisor == '0) begin
                     state      <= DONE;
                     oBusy      <= 1'b0;
                     oDone      <= 1'b1;
                     oQuotient  <= '1;
                     oRemainder <= iDividend;
                  end
`endif
               end
            end
            CALC: begin
               rem     <= rem_next;
               quot    <= quot_next;
               counter <= counter + CW'(1);
               // Last iteration publishes the freshly computed bits directly.
               if (counter == LAST) begin
                  state      <= DONE;
                  oBusy      <= 1'b0;
                  oDone      <= 1'b1;
                  oQuotient  <= quot_next;
                  oRemainder <= rem_next[WIDTH-1:0];
               end
            end
            DONE: begin
               if (iAck) begin
                  state <= IDLE;
                  oDone <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               oBusy <= 1'b0;
               oDone <= 1'b0;
            end
         endcase
      end
   end

endmodule
